// File: rtl/host_cmd_loader.sv
// Host command loader: turns a UART byte stream into imem/dmem load and
// readback traffic plus CPU start/quit strobes for cpu_top.
module host_cmd_loader #(
    parameter int unsigned     TO_W        = 24,
    parameter logic [TO_W-1:0] TIMEOUT_CYC = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [9:0]  i_ram_wadr,
    output logic [31:0] i_ram_wdata,
    output logic        i_ram_wen,
    output logic [9:0]  i_ram_radr,
    output logic        i_read_sel,
    input  logic [31:0] i_ram_rdata,
    output logic [9:0]  d_ram_wadr,
    output logic [31:0] d_ram_wdata,
    output logic        d_ram_wen,
    output logic [9:0]  d_ram_radr,
    output logic        d_read_sel,
    input  logic [31:0] d_ram_rdata,
    output logic        cpu_start,
    output logic [29:0] start_adr,
    output logic        quit_cmd,
    output logic        busy,
    output logic        cmd_err
);

    typedef enum logic [3:0] {
        IDLE,
        ADR,
        CNT,
        WDAT,
        WSTB,
        RD_REQ,
        RD_WAIT,
        RD_SEND,
        GADR
    } state_t;

    state_t          state_q, state_n;
    logic            is_rd_q, is_rd_n;
    logic            is_d_q, is_d_n;
    logic [1:0]      idx_q, idx_n;
    logic [9:0]      addr_q, addr_n;
    logic [8:0]      cnt_q, cnt_n;
    logic [31:0]     sreg_q, sreg_n;
    logic [TO_W-1:0] to_q, to_n;
    logic [29:0]     start_q, start_n;
    logic            go_q, go_n;
    logic            quit_q, quit_n;
    logic            err_q, err_n;
    logic            timed;
    logic            to_exp;
    logic            rd_act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            is_rd_q <= 1'b0;
            is_d_q  <= 1'b0;
            idx_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            sreg_q  <= '0;
            to_q    <= '0;
            start_q <= '0;
            go_q    <= 1'b0;
            quit_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            is_rd_q <= is_rd_n;
            is_d_q  <= is_d_n;
            idx_q   <= idx_n;
            addr_q  <= addr_n;
            cnt_q   <= cnt_n;
            sreg_q  <= sreg_n;
            to_q    <= to_n;
            start_q <= start_n;
            go_q    <= go_n;
            quit_q  <= quit_n;
            err_q   <= err_n;
        end
    end

    // Only packet-collecting states wait on the host, so only they time out
    assign timed = (state_q == ADR) || (state_q == CNT) ||
                   (state_q == WDAT) || (state_q == GADR);

    always_comb begin
        to_n   = '0;
        to_exp = 1'b0;
        if (timed && !rx_valid) begin
            if (to_q == TIMEOUT_CYC - 1'b1) begin
                to_exp = 1'b1;
            end else begin
                to_n = to_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state_q;
        is_rd_n = is_rd_q;
        is_d_n  = is_d_q;
        idx_n   = idx_q;
        addr_n  = addr_q;
        cnt_n   = cnt_q;
        sreg_n  = sreg_q;
        start_n = start_q;
        go_n    = 1'b0;
        quit_n  = 1'b0;
        err_n   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    idx_n = '0;
                    unique case (rx_data)
                        8'h57: begin
                            state_n = ADR;
                            is_rd_n = 1'b0;
                            is_d_n  = 1'b0;
                        end
                        8'h77: begin
                            state_n = ADR;
                            is_rd_n = 1'b0;
                            is_d_n  = 1'b1;
                        end
                        8'h52: begin
                            state_n = ADR;
                            is_rd_n = 1'b1;
                            is_d_n  = 1'b0;
                        end
                        8'h72: begin
                            state_n = ADR;
                            is_rd_n = 1'b1;
                            is_d_n  = 1'b1;
                        end
                        8'h47: state_n = GADR;
                        8'h51: quit_n = 1'b1;
                        default: err_n = 1'b1;
                    endcase
                end
            end
            ADR: begin
                if (rx_valid) begin
                    sreg_n = {sreg_q[23:0], rx_data};
                    idx_n  = idx_q + 2'd1;
                    if (idx_q[0]) begin
                        addr_n  = {sreg_q[1:0], rx_data};
                        idx_n   = '0;
                        state_n = CNT;
                    end
                end
            end
            CNT: begin
                if (rx_valid) begin
                    cnt_n   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                    idx_n   = '0;
                    state_n = is_rd_q ? RD_REQ : WDAT;
                end
            end
            WDAT: begin
                if (rx_valid) begin
                    sreg_n = {sreg_q[23:0], rx_data};
                    idx_n  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_n = WSTB;
                    end
                end
            end
            WSTB: begin
                addr_n = addr_q + 10'd1;
                cnt_n  = cnt_q - 9'd1;
                idx_n  = '0;
                if (cnt_q == 9'd1) begin
                    state_n = IDLE;
                end else begin
                    state_n = WDAT;
                    // A back-to-back byte here is the first of the next word
                    if (rx_valid) begin
                        sreg_n = {sreg_q[23:0], rx_data};
                        idx_n  = 2'd1;
                    end
                end
            end
            RD_REQ: begin
                state_n = RD_WAIT;
            end
            RD_WAIT: begin
                sreg_n  = is_d_q ? d_ram_rdata : i_ram_rdata;
                idx_n   = '0;
                state_n = RD_SEND;
            end
            RD_SEND: begin
                if (tx_ready) begin
                    sreg_n = {sreg_q[23:0], 8'h00};
                    idx_n  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        addr_n  = addr_q + 10'd1;
                        cnt_n   = cnt_q - 9'd1;
                        state_n = (cnt_q == 9'd1) ? IDLE : RD_REQ;
                    end
                end
            end
            GADR: begin
                if (rx_valid) begin
                    sreg_n = {sreg_q[23:0], rx_data};
                    idx_n  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        start_n = {sreg_q[23:0], rx_data[7:2]};
                        go_n    = 1'b1;
                        idx_n   = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (to_exp) begin
            state_n = IDLE;
            idx_n   = '0;
            err_n   = 1'b1;
        end
    end

    assign rd_act = (state_q == RD_REQ) || (state_q == RD_WAIT) ||
                    (state_q == RD_SEND);

    assign i_ram_wadr  = addr_q;
    assign i_ram_wdata = sreg_q;
    assign i_ram_wen   = (state_q == WSTB) && !is_d_q;
    assign i_ram_radr  = addr_q;
    assign i_read_sel  = rd_act && !is_d_q;

    assign d_ram_wadr  = addr_q;
    assign d_ram_wdata = sreg_q;
    assign d_ram_wen   = (state_q == WSTB) && is_d_q;
    assign d_ram_radr  = addr_q;
    assign d_read_sel  = rd_act && is_d_q;

    assign tx_valid  = (state_q == RD_SEND);
    assign tx_data   = sreg_q[31:24];
    assign cpu_start = go_q;
    assign start_adr = start_q;
    assign quit_cmd  = quit_q;
    assign cmd_err   = err_q;
    assign busy      = (state_q != IDLE);

endmodule
